multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 opcode  input  7  Instr[6:0] from the instruction register; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag; sampled in EXEC only.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1 while mem_req is 1.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  memory write enable; valid only with mem_req=1.
REQ-009 ir_write, pc_write, reg_write  output  1 each  register load enables.
REQ-010 pc_src, mem_to_reg, alu_src_a  output  1 each  mux selects; alu_src_a: 0=PC, 1=rs1.
REQ-011 alu_src_b  output  2  00=rs2, 01=constant 4, 10=immediate.
REQ-012 alu_op  output  2  00=add, 01=subtract (branch), 10=funct decode.
REQ-013 state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-014 halted  output  1  high while in TRAP.
REQ-015 instret  output  CNT_W  count of retired instructions.

Function
REQ-016 Decoded opcodes SHALL be R=0110011, I-arith=0010011, LOAD=0000011, STORE=0100011, BEQ=1100011; all others are illegal.
REQ-017 Outputs SHALL be Moore-decoded from state and opcode; any output not listed for a state SHALL be 0.
REQ-018 FETCH: mem_req=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1. The next state SHALL be DECODE when mem_ready=1 and FETCH otherwise.
REQ-019 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut); SHALL go to EXEC for a legal opcode and follow REQ-033 for an illegal one.
REQ-020 EXEC R: alu_src_a=1, alu_src_b=00, alu_op=10; next state WB.
REQ-021 EXEC I-arith: alu_src_a=1, alu_src_b=10, alu_op=10; next state WB.
REQ-022 EXEC LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM.
REQ-023 EXEC BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero; next state FETCH.
REQ-024 MEM: mem_req=1, mem_we=1 for STORE and 0 for LOAD; SHALL hold state until mem_ready=1. LOAD then goes to WB; STORE then goes to FETCH.
REQ-025 WB: reg_write=1 for exactly one cycle, mem_to_reg=1 for LOAD and 0 otherwise; next state FETCH.
REQ-026 Latency: BEQ SHALL take 3 cycles, R/I-arith and STORE 4 cycles, and LOAD 5 cycles, assuming zero-wait memory.
REQ-027 Each memory wait cycle SHALL add exactly one cycle; there is no timeout.
REQ-028 instret SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-029 mem_ready=1 outside FETCH or MEM SHALL be ignored.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set state to FETCH, instret to 0 and halted to 0, overriding any transition, including mid-MEM wait.
REQ-031 Control outputs SHALL be forced to 0 in any cycle where reset=1; the first cycle after release SHALL be FETCH with mem_req=1.
REQ-032 A memory access pending at reset SHALL be abandoned, with no ir_write, reg_write or instret update.

Configuration
REQ-033 With ILLEGAL_TRAP_EN defined, an illegal opcode in DECODE SHALL move to TRAP. TRAP SHALL hold halted=1 and all other control outputs 0 until reset, and SHALL not increment instret.
REQ-034 Without ILLEGAL_TRAP_EN, an illegal opcode SHALL go DECODE->FETCH as a NOP, increment instret by 1, and the TRAP state and halted logic SHALL not exist (halted tied 0).

Verification
REQ-035 Reset, then R opcode with mem_ready=1 always -> states 0,1,2,4,0; reg_write=1 only in WB; instret=1.
REQ-036 LOAD with mem_ready held 0 for 3 MEM cycles -> MEM lasts 4 cycles; WB mem_to_reg=1; total 8 cycles; instret=1.
REQ-037 BEQ with zero=1 -> pc_write=1 and pc_src=1 in EXEC. BEQ with zero=0 -> pc_write=0 in EXEC. Both return to FETCH after 3 cycles.
REQ-038 STORE with 2 FETCH wait cycles -> ir_write is pulsed once on the third FETCH cycle; in MEM mem_we=1; no WB visit.
REQ-039 Reset asserted during a MEM wait -> next cycle state=0, instret=0, reg_write=0.
REQ-040 Opcode 1111111 -> with ILLEGAL_TRAP_EN, halted=1 and state=5, stuck until reset. Without it, FETCH follows DECODE and instret increments by 1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM with retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes enter a halting TRAP state instead of retiring as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             pc_src,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    , TRAP = 3'd5
`endif
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  logic             is_r, is_i, is_load, is_store, is_beq, is_legal;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_legal = is_r | is_i | is_load | is_store | is_beq;

  assign state   = state_q;
  assign instret = instret_q;

`ifdef ILLEGAL_TRAP_EN
  assign halted = (state_q == TRAP) && !reset;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b10;
        if (is_legal) begin
          state_d = EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          state_d = FETCH;
          retire  = 1'b1;
`endif
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        if (is_r) begin
          alu_op  = 2'b10;
          state_d = WB;
        end else if (is_i) begin
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
          state_d   = WB;
        end else if (is_load || is_store) begin
          alu_src_b = 2'b10;
          state_d   = MEM;
        end else begin
          // BEQ; an opcode that changed after DECODE also falls back to FETCH here
          alu_op   = is_beq ? 2'b01 : 2'b00;
          pc_src   = is_beq;
          pc_write = is_beq & zero;
          state_d  = FETCH;
          retire   = 1'b1;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        state_d    = FETCH;
        retire     = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
    // Reset cycle: every control output is held low and no access is launched
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      pc_src     = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      retire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule
